// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the
//               program counter, next-PC selection, the instruction-memory
//               request and the IF/ID pipeline register.
//               Optional build macro FETCH_PERF_CNT_EN adds saturating
//               stall/flush performance counters; when it is undefined both
//               counter ports read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 10,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   pc_write,
    input  logic                   if_id_write,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            pc_out,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc4,
    output logic                   if_id_valid,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_flush_cnt
);

    // PC is always word aligned; low bits of the reset value are dropped.
    localparam logic [31:0] c_reset_pc = RESET_PC & ~32'h3;
    localparam logic [31:0] c_pc_step  = 32'h4;

    logic [31:0] r_pc;
    logic        r_primed;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

    // Redirect source selection: jump wins over a simultaneous taken branch.
    always_comb begin
        w_redirect = jump | branch_taken;
        w_target   = (jump ? jump_target : branch_target) & ~32'h3;
        w_pc_plus4 = r_pc + c_pc_step;
    end

    // Next-PC selection. Until the memory has produced its first word the PC
    // is held so that the first real fetch re-reads the reset address.
    always_comb begin
        w_pc_next = r_pc;
        if (!r_primed) begin
            w_pc_next = r_pc;
        end else if (w_redirect) begin
            w_pc_next = w_target;
        end else if (pc_write) begin
            w_pc_next = w_pc_plus4;
        end
    end

    // Memory always reads the next PC, so its data lines up with r_pc one
    // cycle later. During reset r_pc holds the reset PC and r_primed is 0,
    // which makes the address the reset word address.
    assign imem_en   = 1'b1;
    assign imem_addr = w_pc_next[IMEM_ADDR_W+1:2];

    // Program counter and priming flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pc     <= c_reset_pc;
            r_primed <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_primed <= 1'b1;
        end
    end

    // IF/ID register: flush beats stall because a held instruction on the
    // wrong path must not survive a redirect.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'h0;
            r_if_id_valid <= 1'b0;
        end else if (w_redirect || !r_primed) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= 32'h0;
            r_if_id_valid <= 1'b0;
        end else if (if_id_write) begin
            r_if_id_instr <= imem_rdata;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_valid <= 1'b1;
        end
    end

    assign pc_out      = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating stall and flush counters, cleared only by reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (w_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'h1;
            end
            if (r_primed && !w_redirect && !pc_write &&
                (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'h1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed, table-driven bench for fetch_stage with a
//               synchronous instruction-memory model, plus a second instance
//               with RESET_PC near the top of the address space.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    typedef struct {
        logic        pw;
        logic        iw;
        logic        bt;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        int          e_stall;
        int          e_flush;
    } vec_t;

    logic        clk;
    logic        arst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    logic        rst2_n;
    logic        imem_en2;
    logic [9:0]  imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] pc_out2;
    logic [31:0] if_id_instr2;
    logic [31:0] if_id_pc42;
    logic        if_id_valid2;
    logic [31:0] perf_stall_cnt2;
    logic [31:0] perf_flush_cnt2;

    logic [31:0] mem [1024];

    int n_vec;
    int n_err;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_ADDR_W (10),
        .NOP_INSTR   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    fetch_stage #(
        .RESET_PC    (32'hFFFF_FFF8),
        .IMEM_ADDR_W (10),
        .NOP_INSTR   (32'h0000_0000)
    ) dut_wrap (
        .clk            (clk),
        .arst_n         (rst2_n),
        .pc_write       (1'b1),
        .if_id_write    (1'b1),
        .branch_taken   (1'b0),
        .branch_target  (32'h0),
        .jump           (1'b0),
        .jump_target    (32'h0),
        .imem_en        (imem_en2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .pc_out         (pc_out2),
        .if_id_instr    (if_id_instr2),
        .if_id_pc4      (if_id_pc42),
        .if_id_valid    (if_id_valid2),
        .perf_stall_cnt (perf_stall_cnt2),
        .perf_flush_cnt (perf_flush_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    // Synchronous-read instruction memories, one-cycle latency.
    always @(posedge clk) begin
        imem_rdata  <= mem[imem_addr];
        imem_rdata2 <= mem[imem_addr2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " pc_out"},      pc_out, 32'h0);
        chk({tag, " instr"},       if_id_instr, 32'h0);
        chk({tag, " pc4"},         if_id_pc4, 32'h0);
        chk({tag, " valid"},       {31'h0, if_id_valid}, 32'h0);
        chk({tag, " imem_en"},     {31'h0, imem_en}, 32'h1);
        chk({tag, " imem_addr"},   {22'h0, imem_addr}, 32'h0);
        chk({tag, " stall_cnt"},   perf_stall_cnt, 32'h0);
        chk({tag, " flush_cnt"},   perf_flush_cnt, 32'h0);
    endtask

    vec_t vecs[$];

    task automatic add(input logic pw, input logic iw, input logic bt, input logic [31:0] btgt,
                       input logic jmp, input logic [31:0] jtgt, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid,
                       input int e_stall, input int e_flush);
        vec_t v;
        v.pw = pw; v.iw = iw; v.bt = bt; v.btgt = btgt; v.jmp = jmp; v.jtgt = jtgt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
        v.e_stall = e_stall; v.e_flush = e_flush;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_next;
        logic [31:0] nop;
        nop   = 32'h0;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = memval(i);

        // pw iw bt btgt jmp jtgt | pc instr pc4 valid stall flush
        add(1,1,0,32'h0 ,0,32'h0  , 32'h000, nop           , 32'h000, 0, 0, 0); // priming edge
        add(1,1,0,32'h0 ,0,32'h0  , 32'h004, memval(0)     , 32'h004, 1, 0, 0);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h008, memval(1)     , 32'h008, 1, 0, 0);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h00C, memval(2)     , 32'h00C, 1, 0, 0);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h010, memval(3)     , 32'h010, 1, 0, 0);
        add(0,0,0,32'h0 ,0,32'h0  , 32'h010, memval(3)     , 32'h010, 1, 1, 0); // load-use stall
        add(1,1,0,32'h0 ,0,32'h0  , 32'h014, memval(4)     , 32'h014, 1, 1, 0);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h018, memval(5)     , 32'h018, 1, 1, 0);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h01C, memval(6)     , 32'h01C, 1, 1, 0);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h020, memval(7)     , 32'h020, 1, 1, 0);
        add(1,1,1,32'h40,0,32'h0  , 32'h040, nop           , 32'h000, 0, 1, 1); // taken branch
        add(1,1,0,32'h0 ,0,32'h0  , 32'h044, memval(16)    , 32'h044, 1, 1, 1);
        add(1,1,0,32'h0 ,0,32'h0  , 32'h048, memval(17)    , 32'h048, 1, 1, 1);
        add(0,0,1,32'h40,1,32'h80 , 32'h080, nop           , 32'h000, 0, 1, 2); // jump+branch in stall
        add(1,1,0,32'h0 ,0,32'h0  , 32'h084, memval(32)    , 32'h084, 1, 1, 2);
        add(1,1,0,32'h0 ,1,32'h103, 32'h100, nop           , 32'h000, 0, 1, 3); // misaligned jump
        add(1,1,0,32'h0 ,0,32'h0  , 32'h104, memval(64)    , 32'h104, 1, 1, 3);
        add(1,0,0,32'h0 ,0,32'h0  , 32'h108, memval(64)    , 32'h104, 1, 1, 3); // PC only
        add(0,1,0,32'h0 ,0,32'h0  , 32'h108, memval(66)    , 32'h10C, 1, 2, 3); // IF/ID only
        add(1,1,0,32'h0 ,0,32'h0  , 32'h10C, memval(66)    , 32'h10C, 1, 2, 3);
        add(1,1,1,32'h3F,0,32'h0  , 32'h03C, nop           , 32'h000, 0, 2, 4); // misaligned branch
        add(1,1,0,32'h0 ,0,32'h0  , 32'h040, memval(15)    , 32'h040, 1, 2, 4);

        arst_n = 1'b0; rst2_n = 1'b0;
        pc_write = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;

        step();
        chk_reset_state("reset");
        arst_n = 1'b1;

        foreach (vecs[k]) begin
            pc_write      = vecs[k].pw;
            if_id_write   = vecs[k].iw;
            branch_taken  = vecs[k].bt;
            branch_target = vecs[k].btgt;
            jump          = vecs[k].jmp;
            jump_target   = vecs[k].jtgt;
            step();
            chk($sformatf("v%0d pc_out", k), pc_out, vecs[k].e_pc);
            chk($sformatf("v%0d instr", k), if_id_instr, vecs[k].e_instr);
            chk($sformatf("v%0d pc4", k), if_id_pc4, vecs[k].e_pc4);
            chk($sformatf("v%0d valid", k), {31'h0, if_id_valid}, {31'h0, vecs[k].e_valid});
            chk($sformatf("v%0d stall_cnt", k), perf_stall_cnt, c_perf ? 32'(vecs[k].e_stall) : 32'h0);
            chk($sformatf("v%0d flush_cnt", k), perf_flush_cnt, c_perf ? 32'(vecs[k].e_flush) : 32'h0);
            if (vecs[k].jmp)     exp_next = vecs[k].jtgt & ~32'h3;
            else if (vecs[k].bt) exp_next = vecs[k].btgt & ~32'h3;
            else if (vecs[k].pw) exp_next = vecs[k].e_pc + 32'h4;
            else                 exp_next = vecs[k].e_pc;
            chk($sformatf("v%0d imem_addr", k), {22'h0, imem_addr}, {22'h0, exp_next[11:2]});
        end

        // Asynchronous reset asserted in the middle of a stall.
        pc_write = 1'b0; if_id_write = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        step();
        chk("stall pc_out", pc_out, 32'h040);
        #2;
        arst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        #2;
        arst_n = 1'b1;
        pc_write = 1'b1; if_id_write = 1'b1;
        step();
        chk("reprime pc_out", pc_out, 32'h0);
        chk("reprime valid", {31'h0, if_id_valid}, 32'h0);
        step();
        chk("restart pc_out", pc_out, 32'h4);
        chk("restart instr", if_id_instr, memval(0));
        chk("restart pc4", if_id_pc4, 32'h4);

        // PC wrap-around from the top of the address space.
        chk("wrap reset pc", pc_out2, 32'hFFFF_FFF8);
        chk("wrap reset addr", {22'h0, imem_addr2}, 32'h3FE);
        rst2_n = 1'b1;
        step();
        chk("wrap c1 pc", pc_out2, 32'hFFFF_FFF8);
        chk("wrap c1 valid", {31'h0, if_id_valid2}, 32'h0);
        step();
        chk("wrap c2 pc", pc_out2, 32'hFFFF_FFFC);
        chk("wrap c2 instr", if_id_instr2, memval(1022));
        chk("wrap c2 pc4", if_id_pc42, 32'hFFFF_FFFC);
        step();
        chk("wrap c3 pc", pc_out2, 32'h0000_0000);
        chk("wrap c3 instr", if_id_instr2, memval(1023));
        chk("wrap c3 pc4", if_id_pc42, 32'h0000_0000);
        step();
        chk("wrap c4 pc", pc_out2, 32'h0000_0004);
        chk("wrap c4 instr", if_id_instr2, memval(0));
        chk("wrap imem_en", {31'h0, imem_en2}, 32'h1);
        chk("wrap stall_cnt", perf_stall_cnt2, 32'h0);
        chk("wrap flush_cnt", perf_flush_cnt2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
